// File: rtl/fir_pkg.sv
// Shared FIR definitions: tap count, widths, coefficient type and the
// coefficient-loader state encoding.
package fir_pkg;

    localparam int TAP_COUNT  = 121;
    localparam int COEF_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_W      = $clog2(TAP_COUNT);

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DRAIN   = 2'd2,
        PENDING = 2'd3
    } loader_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient bank: TAP_COUNT x COEF_WIDTH register array.
// Ports:
//   clk, nrst             clock, synchronous active-low reset (clears all words)
//   wr_en/wr_idx/wr_data  single-word indexed write
//   load_en/load_flat     bulk load of every word on one edge (wins over wr_en)
//   rd_flat               flat read-out, word k at [k*COEF_WIDTH +: COEF_WIDTH]
module fir_coef_bank #(
    parameter int TAP_COUNT  = 121,
    parameter int COEF_WIDTH = 16,
    parameter int CNT_W      = 7
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            wr_en,
    input  logic [CNT_W-1:0]                wr_idx,
    input  logic [COEF_WIDTH-1:0]           wr_data,
    input  logic                            load_en,
    input  logic [TAP_COUNT*COEF_WIDTH-1:0] load_flat,
    output logic [TAP_COUNT*COEF_WIDTH-1:0] rd_flat
);

    genvar gi;
    generate
        for (gi = 0; gi < TAP_COUNT; gi++) begin : g_word
            logic [COEF_WIDTH-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (!nrst) begin
                    word_reg <= '0;
                end else if (load_en) begin
                    word_reg <= load_flat[gi*COEF_WIDTH +: COEF_WIDTH];
                end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign rd_flat[gi*COEF_WIDTH +: COEF_WIDTH] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/fir_coef_loader.sv
// Runtime coefficient reload controller for the dual-channel FIR.
// A serial stream of coefficient words fills a shadow bank; a frame of
// exactly TAP_COUNT words (tlast on the last) is committed to the active
// bank in a single edge, only while the FIR is idle (fir_active low).
// Ports:
//   clk, nrst                    clock, synchronous active-low reset
//   cfg_tvalid/tready/tdata/tlast coefficient stream, index 0 first
//   fir_active                   FIR busy with a block; commit is held off
//   coef_flat                    active bank, word k at [k*COEF_WIDTH +: COEF_WIDTH]
//   coef_valid                   active bank loaded at least once since reset
//   busy                         state is not IDLE
//   swap_done                    pulse in the cycle the new coef_flat appears
//   len_err                      pulse on a short or long frame
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int TAP_COUNT  = fir_pkg::TAP_COUNT,
    parameter int COEF_WIDTH = fir_pkg::COEF_WIDTH,
    parameter int CNT_W      = $clog2(TAP_COUNT)
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            cfg_tvalid,
    output logic                            cfg_tready,
    input  logic [COEF_WIDTH-1:0]           cfg_tdata,
    input  logic                            cfg_tlast,
    input  logic                            fir_active,
    output logic [TAP_COUNT*COEF_WIDTH-1:0] coef_flat,
    output logic                            coef_valid,
    output logic                            busy,
    output logic                            swap_done,
    output logic                            len_err
);

    loader_state_t           state_reg;
    logic [CNT_W-1:0]        idx_reg;
    logic                    tready_reg;
    logic                    coef_valid_reg;
    logic                    swap_done_reg;
    logic                    len_err_reg;

    logic                    beat;
    logic                    last_idx;
    logic                    commit;
    logic                    shadow_wr;
    logic [TAP_COUNT*COEF_WIDTH-1:0] shadow_flat;

    assign beat      = cfg_tvalid && tready_reg;
    assign last_idx  = (idx_reg == CNT_W'(TAP_COUNT - 1));
    assign commit    = (state_reg == PENDING) && !fir_active;
    // IDLE keeps idx at 0, so IDLE and LOAD share the same write path.
    assign shadow_wr = beat && ((state_reg == IDLE) || (state_reg == LOAD));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            tready_reg     <= 1'b0;
            coef_valid_reg <= 1'b0;
            swap_done_reg  <= 1'b0;
            len_err_reg    <= 1'b0;
        end else begin
            swap_done_reg <= 1'b0;
            len_err_reg   <= 1'b0;
            tready_reg    <= 1'b1;
            case (state_reg)
                IDLE, LOAD: begin
                    if (beat) begin
                        if (cfg_tlast && last_idx) begin
                            state_reg  <= PENDING;
                            idx_reg    <= '0;
                            tready_reg <= 1'b0;
                        end else if (cfg_tlast) begin
                            // Short frame: shadow is left partial, never committed.
                            len_err_reg <= 1'b1;
                            state_reg   <= IDLE;
                            idx_reg     <= '0;
                        end else if (last_idx) begin
                            // Long frame: swallow the rest up to tlast.
                            len_err_reg <= 1'b1;
                            state_reg   <= DRAIN;
                            idx_reg     <= '0;
                        end else begin
                            state_reg <= LOAD;
                            idx_reg   <= idx_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && cfg_tlast) begin
                        state_reg <= IDLE;
                    end
                end
                PENDING: begin
                    if (commit) begin
                        state_reg      <= IDLE;
                        coef_valid_reg <= 1'b1;
                        swap_done_reg  <= 1'b1;
                    end else begin
                        tready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    fir_coef_bank #(
        .TAP_COUNT (TAP_COUNT),
        .COEF_WIDTH(COEF_WIDTH),
        .CNT_W     (CNT_W)
    ) u_shadow (
        .clk      (clk),
        .nrst     (nrst),
        .wr_en    (shadow_wr),
        .wr_idx   (idx_reg),
        .wr_data  (cfg_tdata),
        .load_en  (1'b0),
        .load_flat('0),
        .rd_flat  (shadow_flat)
    );

    // Active bank only ever changes through the bulk port, so every word
    // switches on the same edge.
    fir_coef_bank #(
        .TAP_COUNT (TAP_COUNT),
        .COEF_WIDTH(COEF_WIDTH),
        .CNT_W     (CNT_W)
    ) u_active (
        .clk      (clk),
        .nrst     (nrst),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_data  ('0),
        .load_en  (commit),
        .load_flat(shadow_flat),
        .rd_flat  (coef_flat)
    );

    assign cfg_tready = tready_reg;
    assign coef_valid = coef_valid_reg;
    assign busy       = (state_reg != IDLE);
    assign swap_done  = swap_done_reg;
    assign len_err    = len_err_reg;

endmodule

// File: tb/tb_fir_coef_loader.sv
module tb_fir_coef_loader;
    import fir_pkg::*;

    logic                            clk = 1'b0;
    logic                            nrst;
    logic                            cfg_tvalid;
    logic                            cfg_tready;
    logic [COEF_WIDTH-1:0]           cfg_tdata;
    logic                            cfg_tlast;
    logic                            fir_active;
    logic [TAP_COUNT*COEF_WIDTH-1:0] coef_flat;
    logic                            coef_valid;
    logic                            busy;
    logic                            swap_done;
    logic                            len_err;

    int checks = 0;
    int passed = 0;

    fir_coef_loader dut (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_tvalid(cfg_tvalid),
        .cfg_tready(cfg_tready),
        .cfg_tdata (cfg_tdata),
        .cfg_tlast (cfg_tlast),
        .fir_active(fir_active),
        .coef_flat (coef_flat),
        .coef_valid(coef_valid),
        .busy      (busy),
        .swap_done (swap_done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    function automatic coef_t get_word(input int k);
        return coef_flat[k*COEF_WIDTH +: COEF_WIDTH];
    endfunction

    // Present one beat and hold it until accepted; returns #1 after the accept edge.
    task automatic send_beat(input logic [COEF_WIDTH-1:0] d, input logic last);
        int n = 0;
        cfg_tvalid = 1'b1;
        cfg_tdata  = d;
        cfg_tlast  = last;
        while (!cfg_tready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cfg_tready) begin
            checks++;
            $display("FAIL beat_timeout: cfg_tready=%0b required 1 within 200 cycles", cfg_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic end_frame();
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; cfg_tvalid = 1'b0; cfg_tdata = '0; cfg_tlast = 1'b0; fir_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (coef_flat !== '0) $display("FAIL reset_coef_flat: got nonzero required 0"); else passed++;
        checks++; if (coef_valid !== 1'b0) $display("FAIL reset_coef_valid: got %0b required 0", coef_valid); else passed++;
        checks++; if (cfg_tready !== 1'b0) $display("FAIL reset_tready: got %0b required 0", cfg_tready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", busy); else passed++;
        nrst = 1'b1;
        @(posedge clk); #1;
        checks++; if (cfg_tready !== 1'b1) $display("FAIL post_reset_tready: got %0b required 1", cfg_tready); else passed++;
        checks++; if (swap_done !== 1'b0 || len_err !== 1'b0) $display("FAIL post_reset_pulses: swap_done=%0b len_err=%0b required 0 0", swap_done, len_err); else passed++;
        $display("reset: released, tready=%0b", cfg_tready);
    endtask

    task automatic test_load();
        int bad = 0;
        for (int k = 0; k < TAP_COUNT; k++) send_beat(COEF_WIDTH'(k + 1), k == TAP_COUNT - 1);
        end_frame();
        checks++; if (busy !== 1'b1 || cfg_tready !== 1'b0 || swap_done !== 1'b0) $display("FAIL load_pending: busy=%0b tready=%0b swap_done=%0b required 1 0 0", busy, cfg_tready, swap_done); else passed++;
        checks++; if (get_word(0) !== 16'sd0) $display("FAIL load_early_commit: word0=%0d required 0", get_word(0)); else passed++;
        @(posedge clk); #1;
        checks++; if (get_word(0) !== 16'sd1) $display("FAIL load_word0: got %0d required 1", get_word(0)); else passed++;
        checks++; if (get_word(120) !== 16'sd121) $display("FAIL load_word120: got %0d required 121", get_word(120)); else passed++;
        for (int k = 0; k < TAP_COUNT; k++) if (get_word(k) !== coef_t'(k + 1)) bad++;
        checks++; if (bad != 0) $display("FAIL load_all_words: %0d words wrong required 0", bad); else passed++;
        checks++; if (coef_valid !== 1'b1 || swap_done !== 1'b1 || busy !== 1'b0) $display("FAIL load_flags: valid=%0b swap_done=%0b busy=%0b required 1 1 0", coef_valid, swap_done, busy); else passed++;
        @(posedge clk); #1;
        checks++; if (swap_done !== 1'b0) $display("FAIL load_swap_pulse_width: got %0b required 0", swap_done); else passed++;
        $display("frame: 121 words k+1 committed");
    endtask

    task automatic test_hold_active();
        int bad = 0;
        fir_active = 1'b1;
        for (int k = 0; k < TAP_COUNT; k++) send_beat(COEF_WIDTH'(k + 1001), k == TAP_COUNT - 1);
        end_frame();
        for (int c = 0; c < 50; c++) begin
            if (get_word(0) !== 16'sd1 || get_word(120) !== 16'sd121 || cfg_tready !== 1'b0 || swap_done !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) $display("FAIL hold_unchanged: %0d bad cycles required 0", bad); else passed++;
        fir_active = 1'b0;
        checks++; if (get_word(0) !== 16'sd1) $display("FAIL hold_no_commit_yet: word0=%0d required 1", get_word(0)); else passed++;
        @(posedge clk); #1;
        checks++; if (get_word(0) !== 16'sd1001 || get_word(120) !== 16'sd1121) $display("FAIL hold_commit: w0=%0d w120=%0d required 1001 1121", get_word(0), get_word(120)); else passed++;
        checks++; if (swap_done !== 1'b1 || cfg_tready !== 1'b1) $display("FAIL hold_swap: swap_done=%0b tready=%0b required 1 1", swap_done, cfg_tready); else passed++;
        @(posedge clk); #1;
        $display("frame: 121 words committed after fir_active dropped");
    endtask

    task automatic test_short_frame();
        int sw = 0;
        for (int k = 0; k < 60; k++) send_beat(16'h1234, k == 59);
        end_frame();
        checks++; if (len_err !== 1'b1 || busy !== 1'b0) $display("FAIL short_len_err: len_err=%0b busy=%0b required 1 0", len_err, busy); else passed++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (swap_done !== 1'b0 || len_err !== 1'b0) sw++;
        end
        checks++; if (sw != 0) $display("FAIL short_no_swap: %0d cycles with swap_done/len_err high required 0", sw); else passed++;
        checks++; if (get_word(0) !== 16'sd1001 || get_word(59) !== 16'sd1060) $display("FAIL short_keep: w0=%0d w59=%0d required 1001 1060", get_word(0), get_word(59)); else passed++;
        $display("frame: short 60-word frame rejected");
    endtask

    task automatic test_long_frame();
        int bad = 0;
        int sw = 0;
        for (int k = 0; k < 130; k++) begin
            send_beat(16'h5555, k == 129);
            if (k == 119) begin
                checks++; if (len_err !== 1'b0) $display("FAIL long_early_err: len_err=%0b required 0", len_err); else passed++;
            end
            if (k == 120) begin
                checks++; if (len_err !== 1'b1 || busy !== 1'b1) $display("FAIL long_err_at_121: len_err=%0b busy=%0b required 1 1", len_err, busy); else passed++;
            end
        end
        end_frame();
        checks++; if (busy !== 1'b0 || len_err !== 1'b0) $display("FAIL long_drain_end: busy=%0b len_err=%0b required 0 0", busy, len_err); else passed++;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (swap_done !== 1'b0) sw++;
        end
        checks++; if (sw != 0 || get_word(0) !== 16'sd1001) $display("FAIL long_no_commit: swaps=%0d w0=%0d required 0 1001", sw, get_word(0)); else passed++;
        $display("frame: long 130-word frame drained");
        for (int k = 0; k < TAP_COUNT; k++) send_beat(16'h7FFF, k == TAP_COUNT - 1);
        end_frame();
        @(posedge clk); #1;
        for (int k = 0; k < TAP_COUNT; k++) if (get_word(k) !== 16'sh7FFF) bad++;
        checks++; if (bad != 0 || swap_done !== 1'b1) $display("FAIL long_recover: %0d bad words swap_done=%0b required 0 1", bad, swap_done); else passed++;
        @(posedge clk); #1;
        $display("frame: 121 words 0x7FFF committed");
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        for (int k = 0; k < 79; k++) send_beat(16'h0AAA, 1'b0);
        cfg_tvalid = 1'b1; cfg_tdata = 16'h0AAA; cfg_tlast = 1'b0;
        nrst = 1'b0;
        @(posedge clk); #1;
        checks++; if (coef_flat !== '0 || coef_valid !== 1'b0) $display("FAIL midreset_clear: valid=%0b w0=%0d required 0 0", coef_valid, get_word(0)); else passed++;
        checks++; if (cfg_tready !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_ctrl: tready=%0b busy=%0b required 0 0", cfg_tready, busy); else passed++;
        end_frame();
        nrst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < TAP_COUNT; k++) send_beat(COEF_WIDTH'(16'hFFFF - k), k == TAP_COUNT - 1);
        end_frame();
        @(posedge clk); #1;
        for (int k = 0; k < TAP_COUNT; k++) if (get_word(k) !== coef_t'(16'hFFFF - k)) bad++;
        checks++; if (get_word(0) !== 16'shFFFF || get_word(120) !== 16'shFF87) $display("FAIL midreset_words: w0=%h w120=%h required ffff ff87", get_word(0), get_word(120)); else passed++;
        checks++; if (bad != 0 || coef_valid !== 1'b1) $display("FAIL midreset_recover: %0d bad words valid=%0b required 0 1", bad, coef_valid); else passed++;
        $display("frame: fresh frame after mid-frame reset committed");
    endtask

    initial begin
        test_reset();
        test_load();
        test_hold_active();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
